ws2812_frame_sched: RTL and testbench
=====================================

Name: ws2812_frame_sched

Overview:
Frame scheduler for a WS2812 LED chain. It holds a double-buffered pixel store written by a host port and streams one 24-bit GRB word per LED to the downstream bit serializer over a valid/ready handshake. After the last pixel it enforces the latch/reset low gap and reports frame completion. It sits between application logic (key/animation sources) and the WS2812 bit-level driver that owns the Di pin.

Parameters:
LED_NUM, 8, number of LEDs in the chain (1..256)
ADDR_W, 8, width of wr_addr; must satisfy 2^ADDR_W >= LED_NUM
CLK_FRE, 27_000_000, clk frequency in Hz
LATCH_US, 80, latch gap in us; LATCH_CYCLES = CLK_FRE/1_000_000*LATCH_US (2160 by default)
REFRESH_HZ, 30, auto-refresh rate; REFRESH_CYCLES = CLK_FRE/REFRESH_HZ (900_000 by default)

Ports:
clk  in  1  system clock
rst  in  1  reset: asynchronous, active-high
wr_en  in  1  host write strobe into the back bank
wr_addr  in  ADDR_W  LED index to write
wr_data  in  24  GRB colour for that LED
swap_req  in  1  pulse: publish the back bank at the next frame start
frame_req  in  1  pulse: request one frame transmission
px_valid  out  1  pixel word valid to the serializer
px_data  out  24  pixel word, MSB sent first
px_last  out  1  qualifies the final pixel of the frame
px_ready  in  1  serializer accepts px_data this cycle
tx_busy  in  1  serializer is still shifting bits
busy  out  1  high from frame start until frame_done
frame_done  out  1  one-cycle pulse at the end of the latch gap

Behaviour:
- Reset (async, rst=1): state=IDLE; px_valid=0, px_data=0, px_last=0, busy=0, frame_done=0; front bank=0; both banks cleared to 0; pending flags, pixel index and timers cleared.
- Storage: 2 banks x LED_NUM x 24b. Host writes always go to the back bank (~front). A write with wr_addr >= LED_NUM is ignored. A write in the same cycle as a swap targets the pre-swap back bank.
- Pending flags: frame_req sets req_pend and swap_req sets swap_pend, in any state. Each flag holds one pending event only; repeated pulses merge.
- State IDLE:
  - Transition trigger is req_pend | swap_pend | refresh tick pending.
  - On trigger: if swap_pend, toggle front and clear swap_pend. Clear req_pend and the refresh flag. Set idx=0, busy=1, go to SEND.
  - In the first SEND cycle, px_valid=1 and px_data = front[0] of the post-swap bank. Latency is 1 clk from trigger seen in IDLE to px_valid.
- State SEND:
  - px_valid stays high. px_data and px_last are stable while px_valid & !px_ready.
  - On px_valid & px_ready with idx < LED_NUM-1: idx++ and the next pixel is presented the next cycle. Back-to-back transfers are allowed (1 pixel/clk max).
  - px_last = (idx == LED_NUM-1). When the transfer completes with px_last high: px_valid=0, px_last=0, go to LATCH.
  - LED_NUM=1 means the first pixel is also last.
- State LATCH:
  - Wait until tx_busy==0, then count LATCH_CYCLES consecutive clk.
  - If tx_busy reasserts during the count, the counter restarts at 0.
  - At the terminal count: frame_done=1 for one cycle, busy=0, go to IDLE.
  - A trigger already pending is serviced in the cycle after frame_done.
- Front bank never changes during SEND/LATCH, so there is no tearing.
- Reset mid-frame aborts immediately: px_valid drops asynchronously and no frame_done is issued.

Optional Feature:
Macro WS2812_AUTO_REFRESH_EN.
- Defined:
  - A free-running counter 0..REFRESH_CYCLES-1 runs in every state and wraps to 0.
  - At the wrap it sets the refresh flag (one pending max), so frames retransmit periodically even without frame_req.
- Undefined:
  - No counter and no refresh flag logic.
  - Frames start only on frame_req or swap_req.

Test Plan:
- Reset, write LED0=24'hFF0000 and LED1=24'h00FF00, swap_req, px_ready=1 -> px_data FF0000 then 00FF00 on consecutive clk (LED_NUM=2). px_last high only on the 2nd. busy=1, then frame_done exactly 2160 clk after tx_busy falls.
- px_ready held low 10 clk mid-frame -> px_valid, px_data and px_last stable all 10 clk. No pixel skipped or duplicated.
- Write during SEND to LED0=24'h0000FF without swap, then frame_req -> current frame and the next frame both send the old LED0. After swap_req, the following frame sends 0000FF.
- frame_req pulsed 3 times during LATCH -> exactly one extra frame, starting the cycle after frame_done.
- tx_busy toggled high at latch count 1000 -> frame_done occurs 2160 clk after the final tx_busy fall.
- rst asserted mid-SEND -> all outputs 0 the same cycle. With WS2812_AUTO_REFRESH_EN defined and REFRESH_HZ scaled so REFRESH_CYCLES=5000, a frame starts every 5000 clk with no frame_req.

Source files
------------

// File: rtl/ws2812_frame_sched_if.sv
// Host write port, pixel stream to the WS2812 bit serializer and frame status.
// slave is the scheduler side, master is the host/serializer side.
interface ws2812_frame_sched_if #(
  parameter int ADDR_W = 8
);
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [23:0]       wr_data;
  logic              swap_req;
  logic              frame_req;
  logic              px_valid;
  logic [23:0]       px_data;
  logic              px_last;
  logic              px_ready;
  logic              tx_busy;
  logic              busy;
  logic              frame_done;

  modport master (
    output wr_en, wr_addr, wr_data, swap_req, frame_req, px_ready, tx_busy,
    input  px_valid, px_data, px_last, busy, frame_done
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, swap_req, frame_req, px_ready, tx_busy,
    output px_valid, px_data, px_last, busy, frame_done
  );
endinterface

// File: rtl/ws2812_frame_sched.sv
// WS2812 frame scheduler: double-buffered GRB store, per-LED pixel streaming and latch gap.
// Optional periodic retransmission is enabled by defining WS2812_AUTO_REFRESH_EN.
module ws2812_frame_sched #(
  parameter int LED_NUM    = 8,
  parameter int ADDR_W     = 8,
  parameter int CLK_FRE    = 27_000_000,
  parameter int LATCH_US   = 80,
  parameter int REFRESH_HZ = 30
) (
  input  logic                  clk,
  input  logic                  rst,
  ws2812_frame_sched_if.slave   bus
);
  localparam int LATCH_CYCLES = CLK_FRE / 1_000_000 * LATCH_US;
  localparam int IDX_W        = (LED_NUM > 1) ? $clog2(LED_NUM) : 1;
  localparam int LCNT_W       = $clog2(LATCH_CYCLES + 1);
  localparam logic [IDX_W-1:0]  LAST_IDX   = IDX_W'(LED_NUM - 1);
  localparam logic [LCNT_W-1:0] LATCH_LAST = LCNT_W'(LATCH_CYCLES - 1);
  localparam logic [ADDR_W:0]   ADDR_LIMIT = (ADDR_W + 1)'(LED_NUM);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SEND  = 2'd1,
    ST_LATCH = 2'd2
  } state_t;

  state_t              state_r, state_s;
  logic                front_r, front_s;
  logic                req_pend_r, req_pend_s;
  logic                swap_pend_r, swap_pend_s;
  logic                refresh_pend_s;
  logic [IDX_W-1:0]    idx_r, idx_s;
  logic [LCNT_W-1:0]   latch_cnt_r, latch_cnt_s;
  logic                px_valid_r, px_valid_s;
  logic [23:0]         px_data_r, px_data_s;
  logic                px_last_r, px_last_s;
  logic                busy_r, busy_s;
  logic                frame_done_r, frame_done_s;
  logic [23:0]         bank_r [2][LED_NUM];

  assign bus.px_valid   = px_valid_r;
  assign bus.px_data    = px_data_r;
  assign bus.px_last    = px_last_r;
  assign bus.busy       = busy_r;
  assign bus.frame_done = frame_done_r;

`ifdef WS2812_AUTO_REFRESH_EN
  localparam int REFRESH_CYCLES = CLK_FRE / REFRESH_HZ;
  localparam int RCNT_W         = $clog2(REFRESH_CYCLES);
  localparam logic [RCNT_W-1:0] REFRESH_LAST = RCNT_W'(REFRESH_CYCLES - 1);

  logic [RCNT_W-1:0] refresh_cnt_r;
  logic              refresh_pend_r;

  // Free-running refresh timer; the wrap raises one pending refresh, consumed by IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      refresh_cnt_r  <= {RCNT_W{1'b0}};
      refresh_pend_r <= 1'b0;
    end else if (refresh_cnt_r == REFRESH_LAST) begin
      refresh_cnt_r  <= {RCNT_W{1'b0}};
      refresh_pend_r <= 1'b1;
    end else begin
      refresh_cnt_r  <= refresh_cnt_r + RCNT_W'(1);
      refresh_pend_r <= refresh_pend_r & (state_r != ST_IDLE);
    end
  end

  assign refresh_pend_s = refresh_pend_r;
`else
  assign refresh_pend_s = 1'b0;
`endif

  // Host writes land in the back bank as seen before any swap in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int b = 0; b < 2; b++) begin
        for (int i = 0; i < LED_NUM; i++) begin
          bank_r[b][i] <= 24'h000000;
        end
      end
    end else if (bus.wr_en && ({1'b0, bus.wr_addr} < ADDR_LIMIT)) begin
      bank_r[~front_r][bus.wr_addr[IDX_W-1:0]] <= bus.wr_data;
    end
  end

  // Next-state and next-output logic; new request pulses win over consumption.
  always_comb begin
    state_s      = state_r;
    front_s      = front_r;
    req_pend_s   = req_pend_r | bus.frame_req;
    swap_pend_s  = swap_pend_r | bus.swap_req;
    idx_s        = idx_r;
    latch_cnt_s  = latch_cnt_r;
    px_valid_s   = px_valid_r;
    px_data_s    = px_data_r;
    px_last_s    = px_last_r;
    busy_s       = busy_r;
    frame_done_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (req_pend_r || swap_pend_r || refresh_pend_s) begin
          front_s     = swap_pend_r ? ~front_r : front_r;
          req_pend_s  = bus.frame_req;
          swap_pend_s = bus.swap_req;
          idx_s       = {IDX_W{1'b0}};
          busy_s      = 1'b1;
          px_valid_s  = 1'b1;
          px_data_s   = bank_r[front_s][{IDX_W{1'b0}}];
          px_last_s   = (LAST_IDX == {IDX_W{1'b0}});
          state_s     = ST_SEND;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_SEND: begin
        if (bus.px_ready && px_last_r) begin
          px_valid_s  = 1'b0;
          px_last_s   = 1'b0;
          px_data_s   = 24'h000000;
          latch_cnt_s = {LCNT_W{1'b0}};
          state_s     = ST_LATCH;
        end else if (bus.px_ready) begin
          idx_s     = idx_r + IDX_W'(1);
          px_data_s = bank_r[front_r][idx_s];
          px_last_s = (idx_s == LAST_IDX);
        end else begin
          state_s = ST_SEND;
        end
      end
      ST_LATCH: begin
        if (bus.tx_busy) begin
          latch_cnt_s = {LCNT_W{1'b0}};
        end else if (latch_cnt_r == LATCH_LAST) begin
          latch_cnt_s  = {LCNT_W{1'b0}};
          frame_done_s = 1'b1;
          busy_s       = 1'b0;
          state_s      = ST_IDLE;
        end else begin
          latch_cnt_s = latch_cnt_r + LCNT_W'(1);
        end
      end
      default: begin
        px_valid_s = 1'b0;
        px_last_s  = 1'b0;
        busy_s     = 1'b0;
        state_s    = ST_IDLE;
      end
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= ST_IDLE;
      front_r      <= 1'b0;
      req_pend_r   <= 1'b0;
      swap_pend_r  <= 1'b0;
      idx_r        <= {IDX_W{1'b0}};
      latch_cnt_r  <= {LCNT_W{1'b0}};
      px_valid_r   <= 1'b0;
      px_data_r    <= 24'h000000;
      px_last_r    <= 1'b0;
      busy_r       <= 1'b0;
      frame_done_r <= 1'b0;
    end else begin
      state_r      <= state_s;
      front_r      <= front_s;
      req_pend_r   <= req_pend_s;
      swap_pend_r  <= swap_pend_s;
      idx_r        <= idx_s;
      latch_cnt_r  <= latch_cnt_s;
      px_valid_r   <= px_valid_s;
      px_data_r    <= px_data_s;
      px_last_r    <= px_last_s;
      busy_r       <= busy_s;
      frame_done_r <= frame_done_s;
    end
  end
endmodule

// File: tb/tb_ws2812_frame_sched.sv
// Self-checking bench for ws2812_frame_sched with a bank/pending-flag reference model.
`timescale 1ns/1ps
module tb_ws2812_frame_sched;
  localparam int LED_NUM      = 2;
  localparam int ADDR_W       = 8;
  localparam int LATCH_CYCLES = 27_000_000 / 1_000_000 * 80;
`ifdef WS2812_AUTO_REFRESH_EN
  localparam int REFRESH_HZ = 5400;
`else
  localparam int REFRESH_HZ = 30;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;

  ws2812_frame_sched_if #(.ADDR_W(ADDR_W)) bus ();

  ws2812_frame_sched #(
    .LED_NUM(LED_NUM), .ADDR_W(ADDR_W), .CLK_FRE(27_000_000),
    .LATCH_US(80), .REFRESH_HZ(REFRESH_HZ)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: two banks, which one is on the front, and a pending publish.
  logic [23:0] m_bank [2][LED_NUM];
  int          m_front;
  bit          m_swap;
  logic [23:0] exp_d [$];
  logic [23:0] got_d [$];
  logic        got_l [$];
  int          start_cyc, end_cyc, unstable, timeout_f;
  logic        start_busy;

  function automatic void model_reset();
    for (int b = 0; b < 2; b++)
      for (int i = 0; i < LED_NUM; i++) m_bank[b][i] = 24'h0;
    m_front = 0;
    m_swap  = 1'b0;
  endfunction

  function automatic void model_frame_start();
    if (m_swap) begin
      m_front = 1 - m_front;
      m_swap  = 1'b0;
    end
    exp_d.delete();
    for (int i = 0; i < LED_NUM; i++) exp_d.push_back(m_bank[m_front][i]);
  endfunction

  task automatic host_write(input int addr, input logic [23:0] data);
    bus.wr_en = 1'b1; bus.wr_addr = ADDR_W'(addr); bus.wr_data = data;
    if (addr < LED_NUM) m_bank[1 - m_front][addr] = data;
    @(negedge clk);
    bus.wr_en = 1'b0;
  endtask

  task automatic pulse_frame_req(output int at);
    at = cyc; bus.frame_req = 1'b1;
    @(negedge clk);
    bus.frame_req = 1'b0;
  endtask

  task automatic pulse_swap(output int at);
    at = cyc; bus.swap_req = 1'b1; m_swap = 1'b1;
    @(negedge clk);
    bus.swap_req = 1'b0;
  endtask

  // Acts as the serializer: mode 0 always ready, 1 random ready, 2 stalls 10 clk after pixel 0.
  task automatic drive_frame(input int mode);
    int guard, stall_left;
    bit stalled, r;
    logic [23:0] hold_d;
    logic hold_l;
    got_d.delete(); got_l.delete();
    unstable = 0; timeout_f = 0; guard = 0; stall_left = 10; stalled = 1'b0;
    hold_d = 24'h0; hold_l = 1'b0;
    while (bus.px_valid !== 1'b1 && guard < 200) begin @(negedge clk); guard++; end
    if (bus.px_valid !== 1'b1) begin timeout_f = 1; return; end
    start_cyc = cyc; start_busy = bus.busy; guard = 0;
    while (bus.px_valid === 1'b1 && guard < 400) begin
      if (stalled && (bus.px_data !== hold_d || bus.px_last !== hold_l)) unstable++;
      case (mode)
        1:       r = ($urandom_range(0, 2) != 0);
        2:       r = !(got_d.size() == 1 && stall_left > 0);
        default: r = 1'b1;
      endcase
      if (!r && mode == 2) stall_left--;
      bus.px_ready = r;
      if (r) begin
        got_d.push_back(bus.px_data); got_l.push_back(bus.px_last); stalled = 1'b0;
      end else begin
        stalled = 1'b1; hold_d = bus.px_data; hold_l = bus.px_last;
      end
      @(negedge clk); guard++;
    end
    end_cyc = cyc; bus.px_ready = 1'b0;
    if (guard >= 400) timeout_f = 1;
  endtask

  // tx_busy profile for the latch phase; delay is clocks from the last tx_busy fall to frame_done.
  task automatic finish_latch(input int first_busy, input int gap, input int second_busy,
                              output int delay, output int early);
    int fall, g;
    delay = -1; early = 0;
    bus.tx_busy = (first_busy > 0);
    for (int i = 0; i < first_busy; i++) @(negedge clk);
    bus.tx_busy = 1'b0; fall = cyc;
    if (second_busy > 0) begin
      for (int i = 0; i < gap; i++) begin @(negedge clk); if (bus.frame_done === 1'b1) early++; end
      bus.tx_busy = 1'b1;
      for (int i = 0; i < second_busy; i++) begin @(negedge clk); if (bus.frame_done === 1'b1) early++; end
      bus.tx_busy = 1'b0; fall = cyc;
    end
    g = 0;
    while (bus.frame_done !== 1'b1 && g < 3000) begin @(negedge clk); g++; end
    if (bus.frame_done === 1'b1) delay = cyc - fall;
  endtask

  task automatic test_reset();
    int at;
    repeat (3) @(negedge clk);
    tests++; if (bus.px_valid !== 1'b0) begin fails++; $display("FAIL rst_px_valid: got %b expected 0", bus.px_valid); end
    tests++; if (bus.px_data !== 24'h0) begin fails++; $display("FAIL rst_px_data: got %h expected 000000", bus.px_data); end
    tests++; if (bus.px_last !== 1'b0) begin fails++; $display("FAIL rst_px_last: got %b expected 0", bus.px_last); end
    tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL rst_busy: got %b expected 0", bus.busy); end
    tests++; if (bus.frame_done !== 1'b0) begin fails++; $display("FAIL rst_frame_done: got %b expected 0", bus.frame_done); end
    pulse_frame_req(at);
    rst = 1'b0;
    model_reset();
    repeat (10) @(negedge clk);
    tests++; if (bus.busy !== 1'b0 || bus.px_valid !== 1'b0) begin fails++; $display("FAIL rst_release_idle: got busy %b valid %b expected 0 0", bus.busy, bus.px_valid); end
  endtask

  task automatic test_basic();
    int at, d, e;
    host_write(0, 24'hFF0000);
    host_write(1, 24'h00FF00);
    host_write($urandom_range(2, 255), 24'($urandom()));
    pulse_swap(at);
    model_frame_start();
    drive_frame(0);
    tests++; if (timeout_f != 0 || got_d.size() != LED_NUM) begin fails++; $display("FAIL basic_len: got %0d pixels timeout %0d expected %0d", got_d.size(), timeout_f, LED_NUM); end
    for (int i = 0; i < LED_NUM && i < got_d.size(); i++) begin
      tests++; if (got_d[i] !== exp_d[i] || got_l[i] !== (i == LED_NUM - 1)) begin fails++; $display("FAIL basic_px%0d: got %h last %b expected %h last %b", i, got_d[i], got_l[i], exp_d[i], i == LED_NUM - 1); end
    end
    tests++; if (exp_d[0] !== 24'hFF0000 || exp_d[1] !== 24'h00FF00) begin fails++; $display("FAIL basic_model: got %h %h expected ff0000 00ff00", exp_d[0], exp_d[1]); end
    tests++; if (start_cyc - at != 2) begin fails++; $display("FAIL basic_latency: got %0d expected 2", start_cyc - at); end
    tests++; if (start_busy !== 1'b1) begin fails++; $display("FAIL basic_busy: got %b expected 1", start_busy); end
    tests++; if (end_cyc - start_cyc != LED_NUM) begin fails++; $display("FAIL basic_b2b: got %0d expected %0d", end_cyc - start_cyc, LED_NUM); end
    finish_latch(5, 0, 0, d, e);
    tests++; if (d != LATCH_CYCLES) begin fails++; $display("FAIL basic_latch: got %0d expected %0d", d, LATCH_CYCLES); end
    @(negedge clk);
    tests++; if (bus.frame_done !== 1'b0 || bus.busy !== 1'b0) begin fails++; $display("FAIL basic_done_pulse: got done %b busy %b expected 0 0", bus.frame_done, bus.busy); end
  endtask

  task automatic test_stall();
    int at, d, e;
    host_write(0, 24'($urandom()) | 24'h1);
    host_write(1, 24'($urandom()) | 24'h1);
    pulse_swap(at);
    model_frame_start();
    drive_frame(2);
    tests++; if (timeout_f != 0 || got_d.size() != LED_NUM) begin fails++; $display("FAIL stall_len: got %0d pixels expected %0d", got_d.size(), LED_NUM); end
    for (int i = 0; i < LED_NUM && i < got_d.size(); i++) begin
      tests++; if (got_d[i] !== exp_d[i] || got_l[i] !== (i == LED_NUM - 1)) begin fails++; $display("FAIL stall_px%0d: got %h last %b expected %h", i, got_d[i], got_l[i], exp_d[i]); end
    end
    tests++; if (unstable != 0) begin fails++; $display("FAIL stall_stable: got %0d changes expected 0", unstable); end
    tests++; if (end_cyc - start_cyc != LED_NUM + 10) begin fails++; $display("FAIL stall_cycles: got %0d expected %0d", end_cyc - start_cyc, LED_NUM + 10); end
    finish_latch(2, 0, 0, d, e);
    tests++; if (d != LATCH_CYCLES) begin fails++; $display("FAIL stall_latch: got %0d expected %0d", d, LATCH_CYCLES); end
  endtask

  task automatic test_no_tear();
    int at, d, e;
    pulse_frame_req(at);
    model_frame_start();
    fork
      drive_frame(2);
      begin repeat (4) @(negedge clk); host_write(0, 24'h0000FF); end
    join
    for (int f = 0; f < 3; f++) begin
      if (f > 0) begin
        if (f == 1) pulse_frame_req(at); else pulse_swap(at);
        model_frame_start();
        drive_frame(0);
      end
      tests++; if (timeout_f != 0 || got_d.size() != LED_NUM) begin fails++; $display("FAIL tear_len%0d: got %0d pixels expected %0d", f, got_d.size(), LED_NUM); end
      for (int i = 0; i < LED_NUM && i < got_d.size(); i++) begin
        tests++; if (got_d[i] !== exp_d[i]) begin fails++; $display("FAIL tear_f%0d_px%0d: got %h expected %h", f, i, got_d[i], exp_d[i]); end
      end
      tests++; if ((got_d.size() > 0 && got_d[0] === 24'h0000FF) != (f == 2)) begin fails++; $display("FAIL tear_f%0d_led0: got %h new colour expected only in frame 2", f, got_d.size() > 0 ? got_d[0] : 24'hx); end
      finish_latch(0, 0, 0, d, e);
      tests++; if (d != LATCH_CYCLES) begin fails++; $display("FAIL tear_latch%0d: got %0d expected %0d", f, d, LATCH_CYCLES); end
    end
  endtask

  task automatic test_latch_merge();
    int at, d, e, extra;
    pulse_frame_req(at);
    model_frame_start();
    drive_frame(1);
    tests++; if (timeout_f != 0 || got_d.size() != LED_NUM || got_d[0] !== exp_d[0]) begin fails++; $display("FAIL merge_first: got %0d pixels expected %0d", got_d.size(), LED_NUM); end
    fork
      finish_latch(0, 0, 0, d, e);
      begin
        repeat (100) @(negedge clk); pulse_frame_req(at);
        repeat (400) @(negedge clk); pulse_frame_req(at);
        repeat (800) @(negedge clk); pulse_frame_req(at);
      end
    join
    tests++; if (d != LATCH_CYCLES) begin fails++; $display("FAIL merge_latch: got %0d expected %0d", d, LATCH_CYCLES); end
    @(negedge clk);
    tests++; if (bus.px_valid !== 1'b1 || bus.frame_done !== 1'b0) begin fails++; $display("FAIL merge_restart: got valid %b done %b expected 1 0", bus.px_valid, bus.frame_done); end
    model_frame_start();
    drive_frame(0);
    for (int i = 0; i < LED_NUM && i < got_d.size(); i++) begin
      tests++; if (got_d[i] !== exp_d[i] || got_l[i] !== (i == LED_NUM - 1)) begin fails++; $display("FAIL merge_px%0d: got %h expected %h", i, got_d[i], exp_d[i]); end
    end
    finish_latch(0, 0, 0, d, e);
    extra = 0;
    repeat (300) begin @(negedge clk); if (bus.px_valid === 1'b1 || bus.busy === 1'b1) extra++; end
    tests++; if (extra != 0) begin fails++; $display("FAIL merge_single: got %0d busy cycles expected 0", extra); end
  endtask

  task automatic test_tx_busy_restart();
    int at, d, e;
    pulse_frame_req(at);
    model_frame_start();
    drive_frame(0);
    tests++; if (timeout_f != 0 || got_d.size() != LED_NUM || got_d[1] !== exp_d[1]) begin fails++; $display("FAIL restart_frame: got %0d pixels expected %0d", got_d.size(), LED_NUM); end
    finish_latch(3, 1000, 4, d, e);
    tests++; if (e != 0) begin fails++; $display("FAIL restart_early: got %0d early done expected 0", e); end
    tests++; if (d != LATCH_CYCLES) begin fails++; $display("FAIL restart_latch: got %0d expected %0d", d, LATCH_CYCLES); end
  endtask

  task automatic test_random();
    int at, d, e;
    for (int it = 0; it < 4; it++) begin
      for (int w = 0; w < 3; w++) host_write($urandom_range(0, 3), 24'($urandom()));
      if ($urandom_range(0, 1) != 0) pulse_swap(at); else pulse_frame_req(at);
      model_frame_start();
      drive_frame(1);
      tests++; if (timeout_f != 0 || got_d.size() != LED_NUM) begin fails++; $display("FAIL rand%0d_len: got %0d pixels expected %0d", it, got_d.size(), LED_NUM); end
      for (int i = 0; i < LED_NUM && i < got_d.size(); i++) begin
        tests++; if (got_d[i] !== exp_d[i] || got_l[i] !== (i == LED_NUM - 1)) begin fails++; $display("FAIL rand%0d_px%0d: got %h last %b expected %h", it, i, got_d[i], got_l[i], exp_d[i]); end
      end
      finish_latch($urandom_range(0, 20), 0, 0, d, e);
      tests++; if (d != LATCH_CYCLES) begin fails++; $display("FAIL rand%0d_latch: got %0d expected %0d", it, d, LATCH_CYCLES); end
    end
  endtask

  task automatic test_reset_mid();
    int at, d, e, g, seen;
    host_write(0, 24'h123456);
    host_write(1, 24'hABCDEF);
    pulse_swap(at);
    g = 0;
    while (bus.px_valid !== 1'b1 && g < 20) begin @(negedge clk); g++; end
    tests++; if (bus.px_valid !== 1'b1 || bus.px_data !== 24'h123456) begin fails++; $display("FAIL rmid_pre: got valid %b data %h expected 1 123456", bus.px_valid, bus.px_data); end
    @(posedge clk); #3; rst = 1'b1; #1;
    tests++; if ({bus.px_valid, bus.px_last, bus.busy, bus.frame_done} !== 4'b0000 || bus.px_data !== 24'h0) begin fails++; $display("FAIL rmid_outputs: got valid %b last %b busy %b done %b data %h expected all 0", bus.px_valid, bus.px_last, bus.busy, bus.frame_done, bus.px_data); end
    @(negedge clk); rst = 1'b0;
    model_reset();
    seen = 0;
    repeat (2500) begin @(negedge clk); if (bus.frame_done === 1'b1 || bus.px_valid === 1'b1) seen++; end
    tests++; if (seen != 0) begin fails++; $display("FAIL rmid_no_done: got %0d active cycles expected 0", seen); end
    pulse_swap(at);
    model_frame_start();
    drive_frame(0);
    tests++; if (timeout_f != 0 || got_d.size() != LED_NUM || got_d[0] !== exp_d[0] || got_d[1] !== exp_d[1]) begin fails++; $display("FAIL rmid_cleared: got %0d pixels first %h expected %h", got_d.size(), got_d.size() > 0 ? got_d[0] : 24'hx, exp_d[0]); end
    finish_latch(0, 0, 0, d, e);
  endtask

`ifdef WS2812_AUTO_REFRESH_EN
  task automatic test_auto_refresh();
    int starts [$];
    logic prev;
    prev = 1'b0;
    bus.px_ready = 1'b1;
    for (int g = 0; g < 22000 && starts.size() < 4; g++) begin
      @(negedge clk);
      if (bus.px_valid === 1'b1 && prev !== 1'b1) starts.push_back(cyc);
      prev = bus.px_valid;
    end
    bus.px_ready = 1'b0;
    tests++; if (starts.size() != 4) begin fails++; $display("FAIL refresh_count: got %0d frames expected 4", starts.size()); end
    for (int i = 1; i < starts.size(); i++) begin
      tests++; if (starts[i] - starts[i-1] != 5000) begin fails++; $display("FAIL refresh_period%0d: got %0d expected 5000", i, starts[i] - starts[i-1]); end
    end
  endtask
`endif

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = 24'h0;
    bus.swap_req = 1'b0; bus.frame_req = 1'b0;
    bus.px_ready = 1'b0; bus.tx_busy = 1'b0;
    model_reset();
    test_reset();
`ifdef WS2812_AUTO_REFRESH_EN
    test_auto_refresh();
`else
    test_basic();
    test_stall();
    test_no_tear();
    test_latch_merge();
    test_tx_busy_restart();
    test_random();
    test_reset_mid();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
